uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Serial UART transmitter that consumes the controller-side transmit handshake (`TxEn`, `TxData`, `nBits`, `baudRate`) and answers with `TxDone`. It sits directly downstream of the UART controller and its functional model, and drives the physical `Tx` line. It sends one frame per request: one start bit, 5–8 data bits LSB first, and one stop bit. All bit timing is derived from a programmable 16x-oversample divisor.

## Interface
- `OVS`, default 16: oversample ticks per bit. Fixed at 16; not intended to be overridden.
- `Clk` in 1: system clock; all logic is on the rising edge.
- `nRst` in 1: synchronous, active-low reset, sampled on the rising edge of `Clk`.
- `TxEn` in 1: transmit request, active high. Sampled only in IDLE; a one-cycle pulse is sufficient.
- `TxData` in 8: frame payload, captured on acceptance.
- `nBits` in 4: data bits per frame, captured on acceptance.
  - Legal values are 5–8.
  - Any other value is treated as 8.
- `baudRate` in 16: tick divisor, captured on acceptance.
  - One tick every `baudRate` clocks.
  - One bit period is 16 × `baudRate` clocks.
- `Tx` out 1: serial line. Idles high.
- `TxDone` out 1: frame complete. Level signal.
- `TxBusy` out 1: high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `Tx`=1, `TxBusy`=0.
  - If `TxEn`=1 and `baudRate`≠0: capture `TxData`, the effective nBits, and `baudRate` into shadow registers; clear `TxDone`; clear the tick divider and the tick count; go to START.
  - If `TxEn`=1 and `baudRate`=0: the request is ignored. Remain in IDLE and leave `TxDone` unchanged.
- Tick divider:
  - Counter runs 0..B−1, where B is the captured baud value.
  - It produces a one-clock tick when it reaches B−1, then wraps to 0.
  - A 4-bit tick counter counts ticks per bit.
  - A bit ends on the tick that completes the 16th tick.
- START: `Tx`=0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - `Tx` = shadow data[index], LSB first.
  - At each bit end, index increments.
  - When index = nBits−1 at bit end, go to STOP.
- STOP: `Tx`=1 for one bit period. At bit end, go to IDLE and set `TxDone`=1.
- `TxDone` behaviour:
  - Sticky: stays high in IDLE until the next accepted request or reset.
  - This lets a level-waiting controller (`wait(TxDone)`) never miss it.
- Mid-frame input changes: `TxEn`, `TxData`, `nBits` and `baudRate` are ignored while `TxBusy`=1. Changes affect only the next frame.
- Reset, whether at power-up or mid-frame:
  - Go to IDLE.
  - `Tx`=1, `TxDone`=0, `TxBusy`=0.
  - Divider, tick counter, bit index and shadow registers are cleared.
  - A partially sent frame is abandoned. No stop bit is appended beyond the line returning high.

## Timing
- `Tx`, `TxDone` and `TxBusy` are all registered. There is no combinational path from inputs to outputs.
- Acceptance:
  - `TxEn` is sampled high at edge N while in IDLE.
  - From edge N: `Tx`=0, `TxBusy`=1, `TxDone`=0.
- Bit period: exactly 16·B clocks for every bit, with no drift and no extra cycles between bits.
- Frame length (acceptance edge to `TxDone` rise): (nBits+2)·16·B clocks.
  - At the edge where `TxDone` rises: `TxBusy` falls and the state returns to IDLE.
  - `Tx` is already 1 from the stop bit.
- Back-to-back frames:
  - `TxEn` may be high on the first IDLE cycle after `TxDone` rises.
  - The next start bit begins at that edge, so the minimum idle gap is 1 clock.
- B=1 is legal: one tick per clock, so a bit lasts 16 clocks.

## Test plan
- Basic frame. Stimulus: B=4, nBits=8, `TxData`=0xA5, one-cycle `TxEn`. Required:
  - `Tx` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1.
  - Each bit lasts 64 clocks.
  - `TxDone` rises exactly 640 clocks after acceptance.
  - `TxBusy` is high for exactly those 640 clocks.
- Short frame and illegal width. Stimulus: nBits=5 with `TxData`=0xFF at B=2. Required:
  - Only 5 data ones are sent.
  - Frame is 7·32 = 224 clocks.
  - Repeating with nBits=0 sends 8 bits: 320 clocks.
- Ignored requests. Required:
  - `TxEn` pulses and `TxData`/`baudRate` changes during a frame alter neither the waveform nor the frame length.
  - `TxEn` with `baudRate`=0 in IDLE leaves `Tx`=1, `TxBusy`=0, and `TxDone` unchanged.
- Back-to-back and sticky done. Required:
  - `TxDone` stays high for 50 idle clocks.
  - `TxEn` on the cycle after `TxDone` rises is accepted: `TxDone` clears and the start bit begins on that edge.
  - A second frame of 0x3C is sent correctly.
- Reset mid-frame. Stimulus: assert `nRst`=0 for 1 clock during data bit 3. Required:
  - At that edge: `Tx`=1, `TxBusy`=0, `TxDone`=0.
  - A subsequent request sends a full correct frame.
- Controller-model integration, 9600 setting (`baudRate`=162). Stimulus: the model's transmit task sends 0x55. Required: the model's `wait(TxDone)` completes after 10·16·162 = 25920 clocks.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, one start bit, 5-8 data bits LSB first, one stop bit.
//   Clk      - system clock, rising edge
//   nRst     - synchronous active-low reset
//   TxEn     - transmit request, sampled only while idle
//   TxData   - frame payload, captured on acceptance
//   nBits    - data bits per frame (5..8, anything else means 8), captured on acceptance
//   baudRate - tick divisor, one tick every baudRate clocks; 0 means the request is ignored
//   Tx       - serial line, idles high
//   TxDone   - sticky frame-complete level, cleared by the next accepted request
//   TxBusy   - high while a frame is in progress
module uart_tx_core #(
    parameter int OVS = 16
) (
    input  logic        Clk,
    input  logic        nRst,
    input  logic        TxEn,
    input  logic [7:0]  TxData,
    input  logic [3:0]  nBits,
    input  logic [15:0] baudRate,
    output logic        Tx,
    output logic        TxDone,
    output logic        TxBusy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [15:0] divCnt;
    logic [3:0]  tickCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shData;
    logic [3:0]  shBits;
    logic [15:0] shBaud;
    logic [3:0]  effBits;
    logic        tick;
    logic        bitEnd;

    always_comb begin
        effBits = (nBits >= 4'd5 && nBits <= 4'd8) ? nBits : 4'd8;
        tick    = divCnt == shBaud - 16'd1;
        // A bit ends on the tick that completes the OVS-th tick of the bit.
        bitEnd  = tick && tickCnt == 4'(OVS - 1);
    end

    always_ff @(posedge Clk) begin
        if (!nRst) begin
            state   <= IDLE;
            divCnt  <= '0;
            tickCnt <= '0;
            bitIdx  <= '0;
            shData  <= '0;
            shBits  <= '0;
            shBaud  <= '0;
            Tx      <= 1'b1;
            TxDone  <= 1'b0;
            TxBusy  <= 1'b0;
        end else begin
            // The divider only runs mid-frame; the tick counter wraps 15 -> 0 on its own.
            if (state != IDLE) begin
                divCnt <= tick ? 16'd0 : divCnt + 16'd1;
                if (tick)
                    tickCnt <= tickCnt + 4'd1;
            end
            case (state)
                IDLE: begin
                    Tx     <= 1'b1;
                    TxBusy <= 1'b0;
                    if (TxEn && baudRate != 16'd0) begin
                        shData  <= TxData;
                        shBits  <= effBits;
                        shBaud  <= baudRate;
                        divCnt  <= '0;
                        tickCnt <= '0;
                        bitIdx  <= '0;
                        TxDone  <= 1'b0;
                        TxBusy  <= 1'b1;
                        Tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        bitIdx <= '0;
                        Tx     <= shData[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        if ({1'b0, bitIdx} == shBits - 4'd1) begin
                            Tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            Tx     <= shData[bitIdx + 3'd1];
                        end
                    end
                end
                default: begin
                    if (bitEnd) begin
                        TxDone <= 1'b1;
                        TxBusy <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed self-checking bench for uart_tx_core.
module tb_uart_tx_core;
    logic        Clk = 1'b0;
    logic        nRst = 1'b0;
    logic        TxEn = 1'b0;
    logic [7:0]  TxData = 8'h00;
    logic [3:0]  nBits = 4'd8;
    logic [15:0] baudRate = 16'd1;
    logic        Tx;
    logic        TxDone;
    logic        TxBusy;
    int          checkCnt = 0;
    int          passCnt = 0;

    always #5 Clk = ~Clk;

    uart_tx_core #(.OVS(16)) dut (
        .Clk(Clk), .nRst(nRst), .TxEn(TxEn), .TxData(TxData), .nBits(nBits),
        .baudRate(baudRate), .Tx(Tx), .TxDone(TxDone), .TxBusy(TxBusy)
    );

    function automatic logic [9:0] frameBits(input logic [7:0] d, input int nb);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) r[i + 1] = d[i];
        r[nb + 1] = 1'b1;
        return r;
    endfunction

    task automatic startFrame(input logic [7:0] d, input logic [3:0] nb, input logic [15:0] b);
        TxData = d;
        nBits = nb;
        baudRate = b;
        TxEn = 1'b1;
        @(posedge Clk); #1;
        TxEn = 1'b0;
    endtask

    // Called just after the acceptance edge; samples the first, middle and last clock of
    // every bit and measures clocks until TxDone rises.
    task automatic captureFrame(input int nb, input int b, input bit perturb,
                                output logic [9:0] first, output logic [9:0] mid,
                                output logic [9:0] last, output int len, output int busyBad);
        int per;
        int k;
        int limit;
        per = 16 * b;
        k = 0;
        limit = (nb + 2) * per + 50;
        first = '0; mid = '0; last = '0;
        len = -1;
        busyBad = 0;
        while (k <= limit) begin
            if (TxDone) begin
                len = k;
                if (TxBusy) busyBad++;
                break;
            end
            if (!TxBusy) busyBad++;
            if (k / per < 10) begin
                if (k % per == 0) first[k / per] = Tx;
                if (k % per == per / 2) mid[k / per] = Tx;
                if (k % per == per - 1) last[k / per] = Tx;
            end
            if (perturb && k % 23 == 7) begin
                TxEn = ~TxEn;
                TxData = 8'($urandom);
                baudRate = 16'($urandom_range(0, 9));
                nBits = 4'($urandom);
            end
            @(posedge Clk); #1;
            k++;
        end
        TxEn = 1'b0;
    endtask

    task automatic test_reset;
        nRst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkCnt++; if (Tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", Tx); else passCnt++;
        checkCnt++; if (TxBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", TxBusy); else passCnt++;
        checkCnt++; if (TxDone !== 1'b0) $display("FAIL reset_done: got %b want 0", TxDone); else passCnt++;
        nRst = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_basic;
        logic [9:0] f, m, l, e;
        int len, bb;
        e = frameBits(8'hA5, 8);
        startFrame(8'hA5, 4'd8, 16'd4);
        checkCnt++; if (Tx !== 1'b0) $display("FAIL basic_accept_tx: got %b want 0", Tx); else passCnt++;
        checkCnt++; if (TxBusy !== 1'b1) $display("FAIL basic_accept_busy: got %b want 1", TxBusy); else passCnt++;
        checkCnt++; if (TxDone !== 1'b0) $display("FAIL basic_accept_done: got %b want 0", TxDone); else passCnt++;
        captureFrame(8, 4, 1'b0, f, m, l, len, bb);
        checkCnt++; if (f !== e) $display("FAIL basic_first: got %b want %b", f, e); else passCnt++;
        checkCnt++; if (m !== e) $display("FAIL basic_mid: got %b want %b", m, e); else passCnt++;
        checkCnt++; if (l !== e) $display("FAIL basic_last: got %b want %b", l, e); else passCnt++;
        checkCnt++; if (len !== 640) $display("FAIL basic_len: got %0d want 640", len); else passCnt++;
        checkCnt++; if (bb !== 0) $display("FAIL basic_busy: got %0d bad cycles want 0", bb); else passCnt++;
        checkCnt++; if (Tx !== 1'b1) $display("FAIL basic_tx_at_done: got %b want 1", Tx); else passCnt++;
    endtask

    task automatic test_short_width;
        logic [9:0] f, m, l, e;
        int len, bb;
        e = frameBits(8'hFF, 5);
        startFrame(8'hFF, 4'd5, 16'd2);
        captureFrame(5, 2, 1'b0, f, m, l, len, bb);
        checkCnt++; if (m !== e) $display("FAIL short_mid: got %b want %b", m, e); else passCnt++;
        checkCnt++; if (len !== 224) $display("FAIL short_len: got %0d want 224", len); else passCnt++;
        e = frameBits(8'hC3, 8);
        startFrame(8'hC3, 4'd0, 16'd2);
        captureFrame(8, 2, 1'b0, f, m, l, len, bb);
        checkCnt++; if (m !== e) $display("FAIL width0_mid: got %b want %b", m, e); else passCnt++;
        checkCnt++; if (len !== 320) $display("FAIL width0_len: got %0d want 320", len); else passCnt++;
        e = frameBits(8'h6B, 8);
        startFrame(8'h6B, 4'd9, 16'd1);
        captureFrame(8, 1, 1'b0, f, m, l, len, bb);
        checkCnt++; if (m !== e) $display("FAIL width9_mid: got %b want %b", m, e); else passCnt++;
        checkCnt++; if (len !== 160) $display("FAIL width9_len: got %0d want 160", len); else passCnt++;
    endtask

    task automatic test_ignored;
        logic [9:0] f, m, l, e;
        int len, bb, bad;
        e = frameBits(8'h96, 8);
        startFrame(8'h96, 4'd8, 16'd3);
        captureFrame(8, 3, 1'b1, f, m, l, len, bb);
        checkCnt++; if (m !== e) $display("FAIL perturb_mid: got %b want %b", m, e); else passCnt++;
        checkCnt++; if (l !== e) $display("FAIL perturb_last: got %b want %b", l, e); else passCnt++;
        checkCnt++; if (len !== 480) $display("FAIL perturb_len: got %0d want 480", len); else passCnt++;
        checkCnt++; if (bb !== 0) $display("FAIL perturb_busy: got %0d bad cycles want 0", bb); else passCnt++;
        TxData = 8'h00;
        baudRate = 16'd0;
        nBits = 4'd8;
        TxEn = 1'b1;
        @(posedge Clk); #1;
        TxEn = 1'b0;
        checkCnt++; if (Tx !== 1'b1) $display("FAIL baud0_tx: got %b want 1", Tx); else passCnt++;
        checkCnt++; if (TxBusy !== 1'b0) $display("FAIL baud0_busy: got %b want 0", TxBusy); else passCnt++;
        checkCnt++; if (TxDone !== 1'b1) $display("FAIL baud0_done: got %b want 1", TxDone); else passCnt++;
        bad = 0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (Tx !== 1'b1 || TxBusy !== 1'b0) bad++;
        end
        checkCnt++; if (bad !== 0) $display("FAIL baud0_idle: got %0d bad cycles want 0", bad); else passCnt++;
    endtask

    task automatic test_back_to_back;
        logic [9:0] f, m, l, e;
        int len, bb, low;
        low = 0;
        repeat (50) begin
            @(posedge Clk); #1;
            if (TxDone !== 1'b1) low++;
        end
        checkCnt++; if (low !== 0) $display("FAIL sticky_done: got %0d low cycles want 0", low); else passCnt++;
        startFrame(8'h12, 4'd8, 16'd1);
        captureFrame(8, 1, 1'b0, f, m, l, len, bb);
        checkCnt++; if (len !== 160) $display("FAIL b2b_first_len: got %0d want 160", len); else passCnt++;
        e = frameBits(8'h3C, 8);
        startFrame(8'h3C, 4'd8, 16'd1);
        checkCnt++; if (TxDone !== 1'b0) $display("FAIL b2b_done_clear: got %b want 0", TxDone); else passCnt++;
        checkCnt++; if (Tx !== 1'b0) $display("FAIL b2b_start_tx: got %b want 0", Tx); else passCnt++;
        checkCnt++; if (TxBusy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", TxBusy); else passCnt++;
        captureFrame(8, 1, 1'b0, f, m, l, len, bb);
        checkCnt++; if (f !== e) $display("FAIL b2b_first: got %b want %b", f, e); else passCnt++;
        checkCnt++; if (l !== e) $display("FAIL b2b_last: got %b want %b", l, e); else passCnt++;
        checkCnt++; if (len !== 160) $display("FAIL b2b_len: got %0d want 160", len); else passCnt++;
    endtask

    task automatic test_reset_mid;
        logic [9:0] f, m, l, e;
        int len, bb, bad;
        startFrame(8'hA5, 4'd8, 16'd2);
        repeat (140) @(posedge Clk);
        #1;
        checkCnt++; if (Tx !== 1'b0) $display("FAIL rst_mid_bit3: got %b want 0", Tx); else passCnt++;
        nRst = 1'b0;
        @(posedge Clk); #1;
        nRst = 1'b1;
        checkCnt++; if (Tx !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", Tx); else passCnt++;
        checkCnt++; if (TxBusy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", TxBusy); else passCnt++;
        checkCnt++; if (TxDone !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", TxDone); else passCnt++;
        bad = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Tx !== 1'b1 || TxBusy !== 1'b0 || TxDone !== 1'b0) bad++;
        end
        checkCnt++; if (bad !== 0) $display("FAIL rst_mid_idle: got %0d bad cycles want 0", bad); else passCnt++;
        e = frameBits(8'h5A, 7);
        startFrame(8'h5A, 4'd7, 16'd2);
        captureFrame(7, 2, 1'b0, f, m, l, len, bb);
        checkCnt++; if (m !== e) $display("FAIL rst_after_mid: got %b want %b", m, e); else passCnt++;
        checkCnt++; if (len !== 288) $display("FAIL rst_after_len: got %0d want 288", len); else passCnt++;
    endtask

    // Controller-model style transmit: pulse the request, then level-wait on TxDone.
    task automatic uartSend(input logic [7:0] d, output int clocks);
        TxData = d;
        nBits = 4'd8;
        baudRate = 16'd162;
        TxEn = 1'b1;
        @(posedge Clk); #1;
        TxEn = 1'b0;
        clocks = 0;
        while (!TxDone && clocks < 30000) begin
            @(posedge Clk); #1;
            clocks++;
        end
    endtask

    task automatic test_controller;
        int clocks;
        uartSend(8'h55, clocks);
        checkCnt++; if (clocks !== 25920) $display("FAIL ctrl_9600_len: got %0d want 25920", clocks); else passCnt++;
        checkCnt++; if (TxDone !== 1'b1) $display("FAIL ctrl_done: got %b want 1", TxDone); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_width();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_controller();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
